// File: rtl/hb_int_mac.sv
`timescale 1ns/1ps
// hb_int_mac: parametrised 2x halfband interpolator, one shared multiplier.
//
// Response: [cK-1 0 ... c1 0 c0 1.0 c0 0 c1 ... 0 cK-1], K runtime-loadable
// coefficient pairs. Every accepted input sample produces two outputs:
// A = centre tap d[K] (unity path) and B = rounded, saturated sum of
// c[k]*(d[K-1-k]+d[K+k]) computed over K MAC cycles.
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   bypass           pass-through mode, sampled only while IDLE
//   in_tdata/tvalid/tready    input stream (valid/ready)
//   out_tdata/tvalid/tready   output stream (valid/ready)
//   coeff_we/addr/data        coefficient write port (taken only in IDLE)
//   sat_clr, sat_flag         sticky saturation flag, present only when the
//                             macro HB_INT_SAT_FLAG_EN is defined
module hb_int_mac #(
  parameter int WIDTH  = 18,
  parameter int CWIDTH = 18,
  parameter int K      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bypass,
  input  logic [WIDTH-1:0]  in_tdata,
  input  logic              in_tvalid,
  output logic              in_tready,
  output logic [WIDTH-1:0]  out_tdata,
  output logic              out_tvalid,
  input  logic              out_tready,
  input  logic              coeff_we,
  input  logic [2:0]        coeff_addr,
  input  logic [CWIDTH-1:0] coeff_data
`ifdef HB_INT_SAT_FLAG_EN
  ,
  input  logic              sat_clr,
  output logic              sat_flag
`endif
);

  localparam int AW   = WIDTH + CWIDTH + 4;
  localparam int NTAP = 2 * K;

  localparam logic signed [AW-1:0] ONE_A    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic signed [AW-1:0] HALF_A   = ONE_A <<< (CWIDTH - 2);
  localparam logic signed [AW-1:0] SAT_HI_A = (ONE_A <<< (WIDTH - 1)) - ONE_A;
  localparam logic signed [AW-1:0] SAT_LO_A = -(ONE_A <<< (WIDTH - 1));

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAC    = 3'd1,
    S_ROUND  = 3'd2,
    S_EMIT_A = 3'd3,
    S_EMIT_B = 3'd4
  } state_t;

  // Clamp a rounded accumulator value to the signed output range.
  function automatic logic [WIDTH-1:0] sat_fn(input logic signed [AW-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > SAT_HI_A) begin
      r = SAT_HI_A[WIDTH-1:0];
    end else if (v < SAT_LO_A) begin
      r = SAT_LO_A[WIDTH-1:0];
    end else begin
      r = v[WIDTH-1:0];
    end
    return r;
  endfunction

`ifdef HB_INT_SAT_FLAG_EN
  // True when the rounded value lies outside the output range.
  function automatic logic clip_fn(input logic signed [AW-1:0] v);
    return (v > SAT_HI_A) || (v < SAT_LO_A);
  endfunction
`endif

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [2:0]                k_r;
  logic signed [AW-1:0]      acc_r;
  logic signed [WIDTH-1:0]   d_r [NTAP];
  logic signed [CWIDTH-1:0]  c_r [K];
  logic [WIDTH-1:0]          b_r;
  logic [WIDTH-1:0]          out_tdata_r;
  logic [WIDTH-1:0]          out_tdata_nxt_s;
  logic                      out_tvalid_r;
  logic                      out_tvalid_nxt_s;
  logic                      run_r;

  logic                      accept_s;
  logic                      out_xfer_s;
  logic                      coeff_take_s;
  logic signed [WIDTH-1:0]   tap_lo_s;
  logic signed [WIDTH-1:0]   tap_hi_s;
  logic signed [CWIDTH-1:0]  coef_s;
  logic signed [WIDTH:0]     pair_s;
  logic signed [AW-1:0]      prod_s;
  logic signed [AW-1:0]      rnd_s;
  logic signed [AW-1:0]      shr_s;

  // run_r keeps in_tready low until the first clock edge after reset release.
  // The bypass formula also holds in normal IDLE, where out_tvalid is low,
  // so a pending bypass output is never overwritten when bypass drops.
  assign in_tready    = run_r && (state_r == S_IDLE) && (!out_tvalid_r || out_tready);
  assign accept_s     = in_tvalid && in_tready;
  assign out_xfer_s   = out_tvalid_r && out_tready;
  assign coeff_take_s = coeff_we && (state_r == S_IDLE);
  assign out_tdata    = out_tdata_r;
  assign out_tvalid   = out_tvalid_r;

  // Select the symmetric tap pair and coefficient for the current MAC step.
  always_comb begin
    tap_lo_s = '0;
    tap_hi_s = '0;
    coef_s   = '0;
    for (int i = 0; i < K; i++) begin
      tap_lo_s = (k_r == 3'(i)) ? d_r[K-1-i] : tap_lo_s;
      tap_hi_s = (k_r == 3'(i)) ? d_r[K+i]   : tap_hi_s;
      coef_s   = (k_r == 3'(i)) ? c_r[i]     : coef_s;
    end
  end

  // Full-precision pair sum and product, rounding (half toward +inf) of acc.
  assign pair_s = {tap_lo_s[WIDTH-1], tap_lo_s} + {tap_hi_s[WIDTH-1], tap_hi_s};
  assign prod_s = AW'(pair_s) * AW'(coef_s);
  assign rnd_s  = acc_r + HALF_A;
  assign shr_s  = rnd_s >>> (CWIDTH - 1);

  // Next-state and next-output decode.
  always_comb begin
    state_nxt_s      = state_r;
    out_tdata_nxt_s  = out_tdata_r;
    if (out_xfer_s) begin
      out_tvalid_nxt_s = 1'b0;
    end else begin
      out_tvalid_nxt_s = out_tvalid_r;
    end
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (bypass) begin
            out_tvalid_nxt_s = 1'b1;
            out_tdata_nxt_s  = in_tdata;
          end else begin
            state_nxt_s = S_MAC;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_MAC: begin
        if (k_r == 3'(K - 1)) begin
          state_nxt_s = S_ROUND;
        end else begin
          state_nxt_s = S_MAC;
        end
      end
      S_ROUND: begin
        state_nxt_s      = S_EMIT_A;
        out_tvalid_nxt_s = 1'b1;
        out_tdata_nxt_s  = d_r[K];
      end
      S_EMIT_A: begin
        if (out_xfer_s) begin
          state_nxt_s      = S_EMIT_B;
          out_tvalid_nxt_s = 1'b1;
          out_tdata_nxt_s  = b_r;
        end else begin
          state_nxt_s = S_EMIT_A;
        end
      end
      S_EMIT_B: begin
        if (out_xfer_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_EMIT_B;
        end
      end
      default: begin
        state_nxt_s      = S_IDLE;
        out_tvalid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, output and handshake registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      out_tdata_r  <= '0;
      out_tvalid_r <= 1'b0;
      run_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      out_tdata_r  <= out_tdata_nxt_s;
      out_tvalid_r <= out_tvalid_nxt_s;
      run_r        <= 1'b1;
    end
  end

  // MAC step counter and accumulator; B is latched in ROUND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_r   <= 3'd0;
      acc_r <= '0;
      b_r   <= '0;
    end else begin
      if (state_r == S_IDLE) begin
        k_r <= 3'd0;
        if (accept_s) begin
          acc_r <= '0;
        end
      end else if (state_r == S_MAC) begin
        k_r   <= k_r + 3'd1;
        acc_r <= acc_r + prod_s;
      end else if (state_r == S_ROUND) begin
        b_r <= sat_fn(shr_s);
      end
    end
  end

  // Delay line shifts on every accepted input, bypass included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAP; i++) begin
        d_r[i] <= '0;
      end
    end else if (accept_s) begin
      d_r[0] <= in_tdata;
      for (int i = 1; i < NTAP; i++) begin
        d_r[i] <= d_r[i-1];
      end
    end
  end

  // Coefficient bank: writes outside IDLE or with an address >= K are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < K; i++) begin
        c_r[i] <= '0;
      end
    end else if (coeff_take_s) begin
      for (int i = 0; i < K; i++) begin
        if (coeff_addr == 3'(i)) begin
          c_r[i] <= coeff_data;
        end
      end
    end
  end

`ifdef HB_INT_SAT_FLAG_EN
  logic sat_flag_r;
  logic sat_set_s;

  assign sat_set_s = (state_r == S_ROUND) && clip_fn(shr_s);
  assign sat_flag  = sat_flag_r;

  // Sticky saturation flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag_r <= 1'b0;
    end else if (sat_set_s) begin
      sat_flag_r <= 1'b1;
    end else if (sat_clr) begin
      sat_flag_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_hb_int_mac.sv
`timescale 1ns/1ps
module tb_hb_int_mac;
  localparam int WIDTH  = 18;
  localparam int CWIDTH = 18;
  localparam int K      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              bypass;
  logic [WIDTH-1:0]  in_tdata;
  logic              in_tvalid;
  logic              in_tready;
  logic [WIDTH-1:0]  out_tdata;
  logic              out_tvalid;
  logic              out_tready;
  logic              coeff_we;
  logic [2:0]        coeff_addr;
  logic [CWIDTH-1:0] coeff_data;
`ifdef HB_INT_SAT_FLAG_EN
  logic              sat_clr;
  logic              sat_flag;
`endif

  always #5 clk = ~clk;

  hb_int_mac #(.WIDTH(WIDTH), .CWIDTH(CWIDTH), .K(K)) dut (
    .clk(clk), .rst(rst), .bypass(bypass),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data)
`ifdef HB_INT_SAT_FLAG_EN
    , .sat_clr(sat_clr), .sat_flag(sat_flag)
`endif
  );

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  longint exp_q[$];
  longint md [0:3];
  longint mc [0:1];

  typedef struct {
    longint x;
    longint a;
    longint b;
  } vec_t;
  vec_t tbl [5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Output scoreboard: a transfer seen at the negedge completes on the next posedge.
  always @(negedge clk) begin : mon_blk
    longint e;
    if (rst && out_tvalid && out_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: actual %0d required no output", $signed(out_tdata));
      end else begin
        e = exp_q.pop_front();
        chk("out_tdata", $signed(out_tdata), e);
      end
    end
  end

  function automatic void mdl_shift(input longint x);
    for (int i = 3; i > 0; i--) md[i] = md[i-1];
    md[0] = x;
  endfunction

  function automatic longint mdl_b();
    longint s;
    s = 0;
    for (int k = 0; k < 2; k++) s += mc[k] * (md[1-k] + md[2+k]);
    s = (s + 65536) >>> 17;
    if (s > 131071) s = 131071;
    else if (s < -131072) s = -131072;
    return s;
  endfunction

  task automatic send(input longint x, output int acc_cyc);
    int n;
    in_tdata  = x[17:0];
    in_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("in_tready_accept", in_tready, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
  endtask

  task automatic send_interp(input longint x);
    int c;
    mdl_shift(x);
    exp_q.push_back(md[2]);
    exp_q.push_back(mdl_b());
    send(x, c);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_tvalid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic write_coeff(input int a, input longint v);
    coeff_we   = 1'b1;
    coeff_addr = 3'(a);
    coeff_data = v[17:0];
    @(posedge clk);
    #1;
    coeff_we = 1'b0;
  endtask

  task automatic load_default();
    write_coeff(0, 75809);
    mc[0] = 75809;
    write_coeff(1, -10690);
    mc[1] = -10690;
  endtask

  task automatic run_table();
    int c;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(tbl[i].a);
      exp_q.push_back(tbl[i].b);
      mdl_shift(tbl[i].x);
      send(tbl[i].x, c);
    end
    drain();
  endtask

  initial begin
    int     c0, c1, c2, n;
    longint held;

    tbl[0] = '{65536, 0,     -5345};
    tbl[1] = '{0,     0,     37905};
    tbl[2] = '{0,     65536, 37905};
    tbl[3] = '{0,     0,     -5345};
    tbl[4] = '{0,     0,     0};
    for (int i = 0; i < 4; i++) md[i] = 0;
    mc[0] = 0;
    mc[1] = 0;

    rst = 1'b1; bypass = 1'b0; in_tdata = '0; in_tvalid = 1'b0; out_tready = 1'b1;
    coeff_we = 1'b0; coeff_addr = 3'd0; coeff_data = '0;
`ifdef HB_INT_SAT_FLAG_EN
    sat_clr = 1'b0;
`endif
    #2 rst = 1'b0;
    #1;
    chk("rst_in_tready", in_tready, 0);
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_out_tdata", $signed(out_tdata), 0);
`ifdef HB_INT_SAT_FLAG_EN
    chk("rst_sat_flag", sat_flag, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    chk("in_tready_before_edge", in_tready, 0);
    @(posedge clk); #1;
    chk("in_tready_after_release", in_tready, 1);

    // Impulse response
    load_default();
    run_table();

    // Latency and minimum input period
    mdl_shift(100);
    exp_q.push_back(md[2]);
    exp_q.push_back(mdl_b());
    send(100, c0);
    for (int j = 0; j <= K + 1; j++) begin
      @(negedge clk);
      if (j == K) chk("tvalid_low_before_latency", out_tvalid, 0);
      if (j == K + 1) chk("tvalid_high_at_latency", out_tvalid, 1);
    end
    mdl_shift(200);
    exp_q.push_back(md[2]);
    exp_q.push_back(mdl_b());
    send(200, c1);
    mdl_shift(300);
    exp_q.push_back(md[2]);
    exp_q.push_back(mdl_b());
    send(300, c2);
    chk("input_period", c2 - c1, K + 4);
    drain();

    // Saturation
`ifdef HB_INT_SAT_FLAG_EN
    chk("sat_flag_quiet", sat_flag, 0);
`endif
    write_coeff(0, 131071); mc[0] = 131071;
    write_coeff(1, 0);      mc[1] = 0;
    for (int i = 0; i < 4; i++) send_interp(131071);
    for (int i = 0; i < 4; i++) send_interp(-131072);
    drain();
`ifdef HB_INT_SAT_FLAG_EN
    chk("sat_flag_set", sat_flag, 1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("sat_flag_clear", sat_flag, 0);
`endif

    // Backpressure held in EMIT_A with a second sample waiting
    load_default();
    out_tready = 1'b0;
    send_interp(5000);
    mdl_shift(7000);
    exp_q.push_back(md[2]);
    exp_q.push_back(mdl_b());
    in_tdata  = 18'd7000;
    in_tvalid = 1'b1;
    n = 0;
    while (!out_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_tvalid_rises", out_tvalid, 1);
    held = $signed(out_tdata);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_tdata_stable", $signed(out_tdata), held);
      chk("bp_in_tready_low", in_tready, 0);
      chk("bp_tvalid_held", out_tvalid, 1);
    end
    @(posedge clk); #1;
    out_tready = 1'b1;
    send(7000, c0);
    drain();

    // Coefficient write timing
    send_interp(3000);
    drain();
    mdl_shift(1000);
    exp_q.push_back(md[2]);
    exp_q.push_back(mdl_b());
    send(1000, c0);
    write_coeff(0, 1000);
    drain();
    write_coeff(0, 1000);
    mc[0] = 1000;
    write_coeff(5, 12345);
    send_interp(2000);
    send_interp(0);
    drain();

    // Bypass, then back to interpolation
    bypass    = 1'b1;
    in_tdata  = 18'd1;
    in_tvalid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      mdl_shift(i);
      exp_q.push_back(i);
    end
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i < 3) chk("byp_in_tready", in_tready, 1);
      if (i > 0) begin
        chk("byp_tvalid", out_tvalid, 1);
        chk("byp_latency_data", $signed(out_tdata), i);
      end
      @(posedge clk); #1;
      if (i < 2) in_tdata = 18'(i + 2);
      else in_tvalid = 1'b0;
    end
    drain();
    bypass = 1'b0;
    send_interp(0);
    send_interp(0);
    drain();

    // Asynchronous reset in the middle of MAC
    send(4000, c0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_tvalid", out_tvalid, 0);
    chk("arst_in_tready", in_tready, 0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) md[i] = 0;
    mc[0] = 0;
    mc[1] = 0;
    #3;
    rst = 1'b1;
    chk("arst_in_tready_before_edge", in_tready, 0);
    @(posedge clk); #1;
    chk("arst_in_tready_after_edge", in_tready, 1);
    send_interp(9000);
    send_interp(9000);
    for (int i = 0; i < 4; i++) send_interp(0);
    drain();
    load_default();
    run_table();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
